product_accumulator: RTL and testbench

- Downstream consumer of the 32x32 signed booth multiplier. It takes the 64-bit signed product stream over a valid/ready handshake and accumulates a job of `len` products into a saturating signed accumulator.
- At the end of each job it presents the sum with a sticky overflow flag over a valid/ready output handshake.
- It is the sequential MAC back end placed after the combinational multiplier.

---
 rtl/product_accumulator_if.sv | 38 +++
 rtl/product_accumulator.sv | 123 ++++++++++++
 tb/tb_product_accumulator.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier-side producer, the product
// accumulator and the result consumer.
//
// Signals:
//   start, len           job start request and job length (products per job)
//   in_valid, in_ready   product stream handshake, product carries the word
//   out_valid, out_ready result handshake, acc_out/overflow carry the result
//   busy                 accumulator is in ACCUM or DONE
//
// Modports:
//   master  side that issues jobs, supplies products and accepts results
//   slave   the accumulator itself
interface product_accumulator_if #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              overflow;
    logic              busy;

    modport master (
        output start, len, in_valid, product, out_ready,
        input  in_ready, out_valid, acc_out, overflow, busy
    );

    modport slave (
        input  start, len, in_valid, product, out_ready,
        output in_ready, out_valid, acc_out, overflow, busy
    );
endinterface

// File: rtl/product_accumulator.sv
// Saturating signed multiply-accumulate back end. Sums a job of `len`
// signed products arriving over a valid/ready stream and presents the
// total plus a sticky overflow flag over a valid/ready result handshake.
//
// Ports:
//   clk   single clock, all state changes on the rising edge
//   rst   synchronous active-high reset, overrides everything
//   bus   product_accumulator_if.slave:
//           start/len            job request, sampled in IDLE only
//           in_valid/in_ready    product transfer handshake
//           product              signed PROD_W-bit product
//           out_valid/out_ready  result handshake
//           acc_out              signed ACC_W-bit accumulator value
//           overflow             sticky saturation flag for the job
//           busy                 high in ACCUM or DONE
module product_accumulator #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    product_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_next;
    logic             overflow;
    logic             overflow_next;

    // One guard bit above the accumulator: the two top bits disagree
    // exactly when the true sum falls outside the ACC_W signed range.
    logic [ACC_W:0]   sum_wide;
    logic             sat_pos;
    logic             sat_neg;
    logic [ACC_W-1:0] sum_sat;

    assign sum_wide = {acc[ACC_W-1], acc}
                    + {{(ACC_W+1-PROD_W){bus.product[PROD_W-1]}}, bus.product};
    assign sat_pos  = ~sum_wide[ACC_W] &  sum_wide[ACC_W-1];
    assign sat_neg  =  sum_wide[ACC_W] & ~sum_wide[ACC_W-1];

    always_comb begin
        sum_sat = sum_wide[ACC_W-1:0];
        if (sat_pos) begin
            sum_sat = ACC_MAX;
        end else if (sat_neg) begin
            sum_sat = ACC_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            remaining <= remaining_next;
            overflow  <= overflow_next;
        end
    end

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        remaining_next = remaining;
        overflow_next  = overflow;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_next      = '0;
                    overflow_next = 1'b0;
                    if (bus.len != '0) begin
                        remaining_next = bus.len;
                        state_next     = ACCUM;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_next       = sum_sat;
                    overflow_next  = overflow | sat_pos | sat_neg;
                    remaining_next = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs depend on state only.
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.acc_out   = acc;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: a table of jobs with their
// final results, a running saturating reference for intermediate values,
// a result queue, and hand-written reset/backpressure sequences.
module tb_product_accumulator;
    localparam int PROD_W = 64;
    localparam int ACC_W  = 64;
    localparam int CNT_W  = 16;

    localparam logic signed [65:0] REF_MAX = 66'sd9223372036854775807;
    localparam logic signed [65:0] REF_MIN = -66'sd9223372036854775808;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int unsigned len;
        longint      p[4];
        int unsigned gap;
        int unsigned bp;
        longint      exp_acc;
        bit          exp_ovf;
    } vec_t;

    typedef struct {
        logic [63:0] acc;
        logic        ovf;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: actual %0d (0x%h) required %0d (0x%h) at %0t",
                     name, $signed(act), act, $signed(req), req, $time);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " in_ready"},  64'(bus.in_ready),  64'd0);
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " busy"},      64'(bus.busy),      64'd0);
        check({tag, " acc_out"},   bus.acc_out,        64'd0);
        check({tag, " overflow"},  64'(bus.overflow),  64'd0);
    endtask

    // Entered and left at a falling edge, inputs idle.
    task automatic run_job(input vec_t v, input int idx);
        logic signed [65:0] m;
        bit                 m_ovf;
        exp_t               e;
        int                 waited;
        string              tag;
        tag   = $sformatf("job%0d", idx);
        m     = '0;
        m_ovf = 1'b0;

        bus.start = 1'b1;
        bus.len   = CNT_W'(v.len);
        if (v.len == 0) sb.push_back('{acc: 64'(v.exp_acc), ovf: v.exp_ovf});
        @(negedge clk);
        bus.start = 1'b0;

        if (v.len != 0) begin
            check({tag, " accum in_ready"}, 64'(bus.in_ready), 64'd1);
            check({tag, " accum busy"},     64'(bus.busy),     64'd1);
            for (int i = 0; i < int'(v.len); i++) begin
                bus.in_valid = 1'b1;
                bus.product  = v.p[i];
                if (i == int'(v.len) - 1) sb.push_back('{acc: 64'(v.exp_acc), ovf: v.exp_ovf});
                @(negedge clk);
                m = m + v.p[i];
                if (m > REF_MAX) begin m = REF_MAX; m_ovf = 1'b1; end
                if (m < REF_MIN) begin m = REF_MIN; m_ovf = 1'b1; end
                check($sformatf("%s step%0d acc", tag, i), bus.acc_out, m[63:0]);
                check($sformatf("%s step%0d ovf", tag, i), 64'(bus.overflow), 64'(m_ovf));
                if (i == 0 && v.gap > 0) begin
                    bus.in_valid = 1'b0;
                    bus.product  = 64'h0123_4567_89ab_cdef;
                    for (int g = 0; g < int'(v.gap); g++) begin
                        @(negedge clk);
                        check({tag, " gap acc"},      bus.acc_out,      m[63:0]);
                        check({tag, " gap in_ready"}, 64'(bus.in_ready), 64'd1);
                    end
                end
            end
            bus.in_valid = 1'b0;
        end

        // Result must appear the cycle after the final transfer.
        check({tag, " latency out_valid"}, 64'(bus.out_valid), 64'd1);
        waited = 0;
        while (!bus.out_valid && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.out_valid) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s timeout: out_valid never rose", tag);
        end
        if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s scoreboard: queue empty", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, " result acc"},  bus.acc_out,        e.acc);
        check({tag, " result ovf"},  64'(bus.overflow),  64'(e.ovf));
        check({tag, " done in_ready"}, 64'(bus.in_ready), 64'd0);

        bus.out_ready = 1'b0;
        for (int b = 0; b < int'(v.bp); b++) begin
            bus.start    = 1'b1;
            bus.len      = CNT_W'(3);
            bus.in_valid = 1'b1;
            bus.product  = 64'd100;
            @(negedge clk);
            check({tag, " bp acc"},       bus.acc_out,        e.acc);
            check({tag, " bp out_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, " bp in_ready"},  64'(bus.in_ready),  64'd0);
        end
        bus.in_valid  = 1'b0;
        // Start coinciding with out_ready must not launch a job.
        bus.start     = (v.bp > 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check({tag, " idle out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " idle busy"},      64'(bus.busy),      64'd0);
        check({tag, " idle acc kept"},  bus.acc_out,        e.acc);
        @(negedge clk);
        check({tag, " idle stays"},     64'(bus.busy),      64'd0);
    endtask

    initial begin
        vecs[0] = '{len: 4, p: '{-2, 2, 2, -2}, gap: 0, bp: 0, exp_acc: 0, exp_ovf: 1'b0};
        vecs[1] = '{len: 2, p: '{-64'sd4294836225, -64'sd131070, 0, 0}, gap: 3, bp: 0,
                    exp_acc: -64'sd4294967295, exp_ovf: 1'b0};
        vecs[2] = '{len: 3, p: '{64'sh4000_0000_0000_0000, 64'sh4000_0000_0000_0000, -1, 0},
                    gap: 0, bp: 0, exp_acc: 64'sh7FFF_FFFF_FFFF_FFFE, exp_ovf: 1'b1};
        vecs[3] = '{len: 3, p: '{64'shC000_0000_0000_0000, 64'shC000_0000_0000_0000,
                    64'shC000_0000_0000_0000, 0}, gap: 0, bp: 0,
                    exp_acc: 64'sh8000_0000_0000_0000, exp_ovf: 1'b1};
        vecs[4] = '{len: 2, p: '{2, 3, 0, 0}, gap: 0, bp: 4, exp_acc: 5, exp_ovf: 1'b0};
        vecs[5] = '{len: 0, p: '{0, 0, 0, 0}, gap: 0, bp: 0, exp_acc: 0, exp_ovf: 1'b0};
        vecs[6] = '{len: 1, p: '{7, 0, 0, 0}, gap: 0, bp: 0, exp_acc: 7, exp_ovf: 1'b0};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.product   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("idle ignores in_valid busy", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 6; i++) run_job(vecs[i], i);

        // Reset in the middle of a job discards the partial sum.
        bus.start = 1'b1;
        bus.len   = CNT_W'(5);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.product  = 64'd10;
        @(negedge clk);
        bus.product  = 64'd20;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("midjob partial acc", bus.acc_out,   64'd30);
        check("midjob busy",        64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("midjob reset");

        run_job(vecs[6], 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
